booth_seq_ctrl: RTL and testbench
=================================

Name: booth_seq_ctrl

Overview:
- Sequential radix-2 Booth multiplier controller.
- Accepts one signed W×W operand pair over a valid/ready handshake and runs one Booth substep per clock on a shared step datapath.
- Returns the 2W-bit signed product over a second valid/ready handshake.
- Sits between operand producers and any consumer of products; replaces the unrolled W-stage combinational chain with a single reused step and a counter-driven FSM.

Parameters:
- W, 4, operand width in bits (W ≥ 2); product width is 2W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller can accept an operand pair
- multiplicand  input  W  signed multiplicand (BR)
- multiplier  input  W  signed multiplier (QR)
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2W  signed product
- busy  output  1  high while in BUSY state

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, AC=0, QR=0, Q_1=0, count=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: BR←multiplicand, QR←multiplier, AC←0 (W+1 bits, sign-extended domain), Q_1←0, count←W; go to BUSY.
- BUSY, each cycle:
  - in_ready=0, busy=1.
  - Apply one step on pair {QR[0],Q_1}: 10 → AC=AC−sext(BR); 01 → AC=AC+sext(BR); 00/11 → no add.
  - Then arithmetic right shift of {AC,QR,Q_1} by 1 (AC MSB replicated). Decrement count.
  - When count reaches 1 at the edge (last step), go to DONE and register product={AC,QR}[2W−1:0] from the post-step value.
- AC is W+1 bits so that all products, including (−2^(W−1))², are exact. Arithmetic within AC wraps modulo 2^(W+1), which never triggers for legal inputs.
- DONE:
  - out_valid=1, product held stable, in_ready=0.
  - On out_ready: out_valid←0, go to IDLE.
  - No back-to-back accept in the same cycle.
- Latency: accept edge → out_valid high after exactly W clock edges (W BUSY cycles). Throughput is one product per W+2 cycles with out_ready tied high.
- in_valid during BUSY/DONE is ignored; the operand is not consumed (in_ready=0). Input operands are sampled only at accept, so changes afterwards are ignored.
- out_ready asserted while out_valid=0 has no effect.
- product retains its last value in IDLE/BUSY; only out_valid qualifies it.
- Reset asserted mid-BUSY or mid-DONE: immediate return to IDLE with the reset values above. The in-flight result is discarded.

Optional Feature:
- Macro BOOTH_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - In BUSY or DONE, abort=1 at an edge returns to IDLE, clears out_valid and busy, and does not update product. abort has priority over out_ready.
  - abort is ignored in IDLE.
- Undefined: the port is absent and the FSM is as described above.

Decomposition:
- Package booth_pkg:
  - state enum (IDLE, BUSY, DONE)
  - Booth pair encoding constants (PAIR_SUB=2'b10, PAIR_ADD=2'b01)
  - function for count width $clog2(W+1)
- Sub-module booth_step: purely combinational single substep.
  - Inputs: AC (W+1), BR (W), QR (W), Q_1.
  - Outputs: next AC, next QR, next Q_1.
  - Instantiated once inside the controller.

Test Plan:
- W=4, multiplicand=3, multiplier=−2, out_ready=1 → out_valid exactly 4 edges after accept, product=8'hFA (−6), in_ready returns 1 the cycle after handshake.
- multiplicand=−8, multiplier=−8 → product=8'h40 (+64); multiplicand=7, multiplier=7 → 8'h31; multiplicand=−8, multiplier=7 → 8'hC8 (−56).
- Exhaustive 256 operand pairs with random out_ready back-pressure → every product matches the signed reference, and product/out_valid stay stable while out_ready=0.
- in_valid held high with new operands during BUSY and DONE → only the first pair is consumed; next accept occurs only after returning to IDLE.
- rst_n pulsed low at the 2nd BUSY cycle → out_valid=0, in_ready=1, busy=0 immediately (asynchronously); the following operation 5×(−3) yields 8'hF1.
- With BOOTH_ABORT_EN, abort at the 3rd BUSY cycle → IDLE next edge, no out_valid, product unchanged from the previous result.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
// Optional abort port is enabled in the controller by defining BOOTH_ABORT_EN.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth recoding of {QR[0], Q_1}
  localparam logic [1:0] PAIR_SUB = 2'b10;
  localparam logic [1:0] PAIR_ADD = 2'b01;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth substep: conditional add/sub of the
// multiplicand into AC, then arithmetic right shift of {AC, QR, Q_1}.
module booth_step
  import booth_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W:0]   ac,
  input  logic [W-1:0] br,
  input  logic [W-1:0] qr,
  input  logic         q_1,
  output logic [W:0]   ac_n,
  output logic [W-1:0] qr_n,
  output logic         q_1_n
);

  logic [W:0] brx;
  logic [W:0] sum;

  always_comb begin
    brx = {br[W-1], br};
    case ({qr[0], q_1})
      PAIR_SUB: sum = ac - brx;
      PAIR_ADD: sum = ac + brx;
      default:  sum = ac;
    endcase
    ac_n  = {sum[W], sum[W:1]};
    qr_n  = {sum[0], qr[W-1:1]};
    q_1_n = qr[0];
  end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: valid/ready in, one substep per clock,
// valid/ready out. Define BOOTH_ABORT_EN to add the abort input.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic           out_valid,
  input  logic           out_ready,
`ifdef BOOTH_ABORT_EN
  input  logic           abort,
`endif
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int CW = cnt_width(W);

  state_t         state, state_n;
  logic [W:0]     ac, ac_n;
  logic [W-1:0]   br;
  logic [W-1:0]   qr, qr_n;
  logic           q_1, q_1_n;
  logic [CW-1:0]  count;
  logic           abort_w;
  logic           last_step;

`ifdef BOOTH_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign last_step = (count == CW'(1));

  booth_step #(.W(W)) u_step (
    .ac    (ac),
    .br    (br),
    .qr    (qr),
    .q_1   (q_1),
    .ac_n  (ac_n),
    .qr_n  (qr_n),
    .q_1_n (q_1_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (in_valid)                   state_n = BUSY;
      BUSY: if (abort_w)                    state_n = IDLE;
            else if (last_step)             state_n = DONE;
      DONE: if (abort_w || out_ready)       state_n = IDLE;
      default:                              state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == BUSY);
    out_valid = (state == DONE);
  end

  // Product is captured from the post-step value so it is ready on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac      <= '0;
      br      <= '0;
      qr      <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            br    <= multiplicand;
            qr    <= multiplier;
            ac    <= '0;
            q_1   <= 1'b0;
            count <= CW'(W);
          end
        end
        BUSY: begin
          if (!abort_w) begin
            ac    <= ac_n;
            qr    <= qr_n;
            q_1   <= q_1_n;
            count <= count - CW'(1);
            if (last_step) product <= {ac_n[W-1:0], qr_n};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl (W=4): directed table, exhaustive
// sweep with random back-pressure, and hand-written corner sequences.
module tb_booth_seq_ctrl;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] product;
  logic           busy;
`ifdef BOOTH_ABORT_EN
  logic           abort = 1'b0;
`endif

  booth_seq_ctrl #(.W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
`ifdef BOOTH_ABORT_EN
    .abort        (abort),
`endif
    .product      (product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int or_mode = 0;  // 0: out_ready=1, 1: random, 2: out_ready=0

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Back-pressure driver
  initial begin
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor / scoreboard, plus hold-stability under back-pressure
  logic       hold_chk = 1'b0;
  logic [7:0] hold_val = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        check("hold_out_valid", 16'(out_valid), 16'd1);
        check("hold_product", 16'(product), 16'(hold_val));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_output");
        else check("product", 16'(product), 16'(exp_q.pop_front()));
        hold_chk = 1'b0;
      end else if (out_valid) begin
        hold_chk = 1'b1;
        hold_val = product;
      end else begin
        hold_chk = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    wait_ready();
    if (!in_ready) begin
      fail_now("in_ready_timeout");
      return;
    end
    multiplicand = a;
    multiplier   = b;
    in_valid     = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{4'd3,  4'hE, 8'hFA};
    vt[1] = '{4'h8,  4'h8, 8'h40};
    vt[2] = '{4'd7,  4'd7, 8'h31};
    vt[3] = '{4'h8,  4'd7, 8'hC8};
    vt[4] = '{4'd5,  4'hD, 8'hF1};

    // Reset state
    #12;
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_product", 16'(product), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: 3 x -2, out_valid exactly W edges after accept
    @(posedge clk); #1;
    multiplicand = 4'd3;
    multiplier   = 4'hE;
    in_valid     = 1'b1;
    check("lat_in_ready", 16'(in_ready), 16'd1);
    exp_q.push_back(8'hFA);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_busy", 16'(busy), 16'd1);
    check("lat_in_ready_busy", 16'(in_ready), 16'd0);
    for (int k = 1; k <= W; k++) begin
      @(posedge clk); #1;
      check("lat_out_valid", 16'(out_valid), 16'(k == W));
    end
    check("lat_product", 16'(product), 16'hFA);
    @(posedge clk); #1;
    check("lat_in_ready_after", 16'(in_ready), 16'd1);
    check("lat_out_valid_after", 16'(out_valid), 16'd0);
    drain();

    // Directed table
    for (int i = 0; i < 5; i++) do_op(vt[i].a, vt[i].b, vt[i].exp);
    drain();

    // Exhaustive with random back-pressure
    or_mode = 1;
    for (int i = -8; i < 8; i++) begin
      for (int j = -8; j < 8; j++) begin
        int p;
        p = i * j;
        do_op(4'(i), 4'(j), 8'(p));
      end
    end
    drain();

    // in_valid held during BUSY/DONE: only the first pair is consumed
    or_mode = 2;
    wait_ready();
    multiplicand = 4'd2;
    multiplier   = 4'd3;
    in_valid     = 1'b1;
    exp_q.push_back(8'h06);
    @(posedge clk); #1;
    multiplicand = 4'd7;
    multiplier   = 4'd7;
    for (int k = 0; k < W + 3; k++) begin
      check("hold_in_ready_low", 16'(in_ready), 16'd0);
      @(posedge clk); #1;
    end
    check("hold_done_valid", 16'(out_valid), 16'd1);
    or_mode = 0;
    wait_ready();
    if (!in_ready) fail_now("second_accept_timeout");
    else exp_q.push_back(8'h31);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Asynchronous reset at the 2nd BUSY cycle
    wait_ready();
    multiplicand = 4'd4;
    multiplier   = 4'd4;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", 16'(busy), 16'd1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 16'(out_valid), 16'd0);
    check("arst_in_ready", 16'(in_ready), 16'd1);
    check("arst_busy", 16'(busy), 16'd0);
    check("arst_product", 16'(product), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'd5, 4'hD, 8'hF1);
    drain();
    check("post_rst_product", 16'(product), 16'hF1);

`ifdef BOOTH_ABORT_EN
    // Abort at the 3rd BUSY cycle: back to IDLE, product untouched
    wait_ready();
    multiplicand = 4'd7;
    multiplier   = 4'd7;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_busy", 16'(busy), 16'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_in_ready", 16'(in_ready), 16'd1);
    check("abort_busy_low", 16'(busy), 16'd0);
    check("abort_out_valid", 16'(out_valid), 16'd0);
    check("abort_product", 16'(product), 16'hF1);
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk); #1;
      check("abort_no_valid", 16'(out_valid), 16'd0);
    end
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
